// File: rtl/smj_dealer.sv
// Tile dealer: deals five legal codes, at most 4 copies each, from an LFSR-driven 136-tile wall.
// Latency >=5 DRAW cycles per hand; the hand is held in HOLD until out_valid&&out_ready, and controls act only in IDLE.
module smj_dealer #(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
  parameter int unsigned WALL_SIZE    = 136
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        shuffle,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [5:0]  hand_n0,
  output logic [5:0]  hand_n1,
  output logic [5:0]  hand_n2,
  output logic [5:0]  hand_n3,
  output logic [5:0]  hand_n4,
  output logic        busy,
  output logic [7:0]  tiles_left,
  output logic        wall_empty
);

  typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;

  localparam logic [7:0] WALL_FULL = 8'(WALL_SIZE);

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [2:0]  cnt [64];
  logic [2:0]  slot;
  logic [5:0]  hand [5];
  logic [5:0]  cand;
  logic        accept;

  function automatic logic is_legal(input logic [5:0] c);
    if (c[5:4] == 2'b00) return c[3:0] <= 4'd6;
    return c[3:0] <= 4'd8;
  endfunction

  assign cand       = lfsr[5:0];
  // cnt[...][2] set means the fourth copy has already been dealt
  assign accept     = is_legal(cand) && !cnt[cand][2];
  assign lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign wall_empty = tiles_left < 8'd5;

  assign hand_n0 = hand[0];
  assign hand_n1 = hand[1];
  assign hand_n2 = hand[2];
  assign hand_n3 = hand[3];
  assign hand_n4 = hand[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= SEED_DEFAULT;
      tiles_left <= WALL_FULL;
      slot       <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i < 64; i++) cnt[i] <= '0;
      for (int i = 0; i < 5; i++) hand[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (shuffle) begin
            tiles_left <= WALL_FULL;
            for (int i = 0; i < 64; i++) cnt[i] <= '0;
          end else if (seed_load) begin
            lfsr <= (seed == 16'h0000) ? SEED_DEFAULT : seed;
          end else if (start && !wall_empty) begin
            slot  <= '0;
            busy  <= 1'b1;
            state <= DRAW;
          end
        end
        DRAW: begin
          lfsr <= lfsr_next;
          if (accept) begin
            hand[slot] <= cand;
            cnt[cand]  <= cnt[cand] + 3'd1;
            slot       <= slot + 3'd1;
            if (slot == 3'd4) begin
              tiles_left <= tiles_left - 8'd5;
              busy       <= 1'b0;
              out_valid  <= 1'b1;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smj_dealer.sv
// Directed bench for smj_dealer: reference wall model, IDLE control vector table, reset and handshake sequences.
module tb_smj_dealer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        shuffle = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [5:0]  hand_n0, hand_n1, hand_n2, hand_n3, hand_n4;
  logic        busy;
  logic [7:0]  tiles_left;
  logic        wall_empty;

  smj_dealer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .shuffle(shuffle),
    .seed_load(seed_load), .seed(seed), .out_ready(out_ready),
    .out_valid(out_valid), .hand_n0(hand_n0), .hand_n1(hand_n1),
    .hand_n2(hand_n2), .hand_n3(hand_n3), .hand_n4(hand_n4),
    .busy(busy), .tiles_left(tiles_left), .wall_empty(wall_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_lfsr;
  int          m_cnt [64];
  int          m_tiles;
  logic [5:0]  exp_hand [5];
  int          exp_cycles;
  int          seen [64];
  logic [5:0]  first_hand [5];

  typedef struct {
    string       name;
    bit          sh;
    bit          sl;
    bit          st;
    logic [15:0] sd;
    bit          e_busy;
    int          e_tiles;
    bit          e_we;
  } vec_t;

  vec_t vec [5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit tb_illegal(input logic [5:0] c);
    return (c == 6'h07) || (c == 6'h08) || (c[3:0] >= 4'd9);
  endfunction

  function automatic logic [5:0] dut_hand(input int i);
    case (i)
      0: return hand_n0;
      1: return hand_n1;
      2: return hand_n2;
      3: return hand_n3;
      default: return hand_n4;
    endcase
  endfunction

  function automatic vec_t mk(input string n, input bit sh, input bit sl, input bit st,
                              input logic [15:0] sd, input bit eb, input int et, input bit ew);
    vec_t v;
    v.name = n; v.sh = sh; v.sl = sl; v.st = st; v.sd = sd;
    v.e_busy = eb; v.e_tiles = et; v.e_we = ew;
    return v;
  endfunction

  task automatic model_reset();
    m_lfsr  = 16'hACE1;
    m_tiles = 136;
    for (int i = 0; i < 64; i++) m_cnt[i] = 0;
  endtask

  task automatic model_hand();
    int k;
    logic [5:0] c;
    k = 0;
    exp_cycles = 0;
    while (k < 5 && exp_cycles < 20000) begin
      c = m_lfsr[5:0];
      if (!tb_illegal(c) && m_cnt[c] < 4) begin
        exp_hand[k] = c;
        m_cnt[c]++;
        k++;
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      exp_cycles++;
    end
    m_tiles -= 5;
  endtask

  task automatic check_hand(input string tag);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s hand_n%0d", tag, i), int'(dut_hand(i)), int'(exp_hand[i]));
  endtask

  // One full hand; hold = cycles of out_ready=0 in HOLD, poke = pulse shuffle/seed_load in DRAW and HOLD
  task automatic do_hand(input string tag, input int hold, input bit poke);
    int cyc;
    model_hand();
    @(negedge clk);
    start = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    for (int it = 0; it < 20000 && !out_valid; it++) begin
      if (busy) cyc++;
      shuffle = poke;
      seed_load = poke;
      seed = 16'h1234;
      @(negedge clk);
      shuffle = 1'b0;
      seed_load = 1'b0;
    end
    check({tag, " out_valid rise"}, int'(out_valid), 1);
    check({tag, " busy cycles"}, cyc, exp_cycles);
    check_hand(tag);
    for (int i = 0; i < 5; i++) seen[dut_hand(i)]++;
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        shuffle = poke;
        seed_load = poke;
        @(negedge clk);
        shuffle = 1'b0;
        seed_load = 1'b0;
      end
      check({tag, " held out_valid"}, int'(out_valid), 1);
      check_hand({tag, " held"});
      out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, " out_valid drop"}, int'(out_valid), 0);
    check({tag, " busy idle"}, int'(busy), 0);
    check({tag, " tiles_left"}, int'(tiles_left), m_tiles);
    out_ready = 1'b0;
  endtask

  task automatic apply_vec(input int i);
    @(negedge clk);
    shuffle = vec[i].sh;
    seed_load = vec[i].sl;
    start = vec[i].st;
    seed = vec[i].sd;
    if (vec[i].sh) begin
      for (int c = 0; c < 64; c++) m_cnt[c] = 0;
      m_tiles = 136;
    end else if (vec[i].sl) begin
      m_lfsr = (vec[i].sd == 16'h0000) ? 16'hACE1 : vec[i].sd;
    end
    @(negedge clk);
    shuffle = 1'b0;
    seed_load = 1'b0;
    start = 1'b0;
    check({vec[i].name, " busy"}, int'(busy), int'(vec[i].e_busy));
    check({vec[i].name, " tiles_left"}, int'(tiles_left), vec[i].e_tiles);
    check({vec[i].name, " wall_empty"}, int'(wall_empty), int'(vec[i].e_we));
    check({vec[i].name, " out_valid"}, int'(out_valid), 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " out_valid"}, int'(out_valid), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " tiles_left"}, int'(tiles_left), 136);
    check({tag, " wall_empty"}, int'(wall_empty), 0);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s hand_n%0d", tag, i), int'(dut_hand(i)), 0);
  endtask

  initial begin
    int viol;
    int total;

    vec[0] = mk("start on short wall", 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1,   1'b1);
    vec[1] = mk("shuffle priority",    1'b1, 1'b1, 1'b1, 16'hBEEF, 1'b0, 136, 1'b0);
    vec[2] = mk("idle quiet",          1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 136, 1'b0);
    vec[3] = mk("seed load",           1'b0, 1'b1, 1'b0, 16'h1D2C, 1'b0, 131, 1'b0);
    vec[4] = mk("seed zero",           1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 136, 1'b0);

    for (int i = 0; i < 64; i++) seen[i] = 0;
    model_reset();

    @(negedge clk);
    @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    // First hand from the default seed: first two accepted codes worked out by hand
    do_hand("hand1", 0, 1'b0);
    check("hand1 n0 literal", int'(hand_n0), 'h21);
    check("hand1 n1 literal", int'(hand_n1), 'h03);
    for (int i = 0; i < 5; i++) first_hand[i] = dut_hand(i);

    do_hand("backpressure", 20, 1'b0);
    do_hand("ignored ctrl", 5, 1'b1);
    for (int h = 4; h <= 27; h++) do_hand($sformatf("hand%0d", h), 0, 1'b0);

    check("exhausted tiles_left", int'(tiles_left), 1);
    check("exhausted wall_empty", int'(wall_empty), 1);
    viol = 0;
    total = 0;
    for (int c = 0; c < 64; c++) begin
      total += seen[c];
      if (seen[c] > 4) viol++;
      if (seen[c] > 0 && tb_illegal(6'(c))) viol++;
    end
    check("wall copy/legality violations", viol, 0);
    check("wall codes dealt", total, 135);

    for (int i = 0; i < 3; i++) apply_vec(i);
    do_hand("after shuffle", 0, 1'b0);
    apply_vec(3);
    do_hand("after seed load", 3, 1'b0);

    // Asynchronous reset while a hand is being drawn
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("pre-reset busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1 check_reset("mid-draw reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply_vec(4);
    do_hand("post reset", 0, 1'b0);
    for (int i = 0; i < 5; i++)
      check($sformatf("replay hand_n%0d", i), int'(dut_hand(i)), int'(first_hand[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
